// File: rtl/systolic_seq.sv
// systolic_seq: sequencer for a 4x4 output-stationary systolic MAC array.
//
// Holds a 4x4 A (activation) tile and a 4x4 B (weight) tile loaded by the host.
// On start it runs one job:
//   IDLE -> CLEAR (1 cycle) -> FEED (10 cycles, t = 0..9) -> DONE (1 cycle) -> IDLE.
// In FEED, row i of A enters on a_out<i> delayed by i cycles, and column j of B
// enters on b_out<j> delayed by j cycles. This is the diagonal skew the array
// needs so that matching k terms meet in each PE. When done pulses, the array's
// c outputs hold A x B.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_addr/  tile write port (sel 0 = A, 1 = B; addr = row*4+col),
//   wr_data                accepted only in IDLE
//   start                  begin a job (sampled only in IDLE)
//   busy                   high from CLEAR through DONE
//   done                   one-cycle pulse at job end
//   arr_clr_n              active-low accumulator clear for the array
//   arr_we                 array accumulate enable (high throughout FEED)
//   a_out0..3 / b_out0..3  row / column edge data to the array
//   job_cnt, busy_cyc      perf counters, present only with SEQ_PERF_CNT_EN
//
// Optional feature macro: SEQ_PERF_CNT_EN.
//
// Every output is a flop. The flops load from the next-state decode, so each
// output lines up with the state it belongs to.

module systolic_seq #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [3:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  arr_clr_n,
    output logic                  arr_we,
    output logic [DATA_WIDTH-1:0] a_out0,
    output logic [DATA_WIDTH-1:0] a_out1,
    output logic [DATA_WIDTH-1:0] a_out2,
    output logic [DATA_WIDTH-1:0] a_out3,
    output logic [DATA_WIDTH-1:0] b_out0,
    output logic [DATA_WIDTH-1:0] b_out1,
    output logic [DATA_WIDTH-1:0] b_out2,
    output logic [DATA_WIDTH-1:0] b_out3
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]           job_cnt,
    output logic [15:0]           busy_cyc
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StFeed,
        StDone
    } state_e;

    localparam logic [3:0] LastStep = 4'd9;

    state_e state_q, state_d;
    logic [3:0] t_q, t_d;

    logic [DATA_WIDTH-1:0] a_buf_q [16];
    logic [DATA_WIDTH-1:0] b_buf_q [16];

    logic [DATA_WIDTH-1:0] a_d [4];
    logic [DATA_WIDTH-1:0] b_d [4];
    logic [DATA_WIDTH-1:0] a_q [4];
    logic [DATA_WIDTH-1:0] b_q [4];

    logic busy_q, done_q, arr_clr_n_q, arr_we_q;
    logic buf_wr;

    // ------------------------------------------------------------------
    // Tile buffers. Writes are accepted only in IDLE, so the tile cannot
    // change during a job.
    // ------------------------------------------------------------------
    assign buf_wr = wr_en && (state_q == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                a_buf_q[k] <= '0;
                b_buf_q[k] <= '0;
            end
        end else if (buf_wr) begin
            if (wr_sel) begin
                b_buf_q[wr_addr] <= wr_data;
            end else begin
                a_buf_q[wr_addr] <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and step counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StFeed;
                t_d     = 4'd0;
            end
            StFeed: begin
                if (t_q == LastStep) begin
                    state_d = StDone;
                    t_d     = 4'd0;
                end else begin
                    t_d = t_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                t_d     = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Edge data for the next cycle.
    // a_out_i = A[i][t-i] and b_out_j = B[t-j][j] when 0 <= t-idx <= 3.
    // Otherwise the output is 0, which also covers the drain steps t = 7..9.
    // If the job starts in the same cycle as a tile write, the write has
    // already landed before t = 0 is decoded (decode happens during CLEAR).
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_d[i] = '0;
            b_d[i] = '0;
            if ((state_d == StFeed) && (t_d >= 4'(i)) && (t_d <= 4'(i + 3))) begin
                a_d[i] = a_buf_q[{i[1:0], 2'(t_d - 4'(i))}];
                b_d[i] = b_buf_q[{2'(t_d - 4'(i)), i[1:0]}];
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            t_q         <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arr_clr_n_q <= 1'b1;
            arr_we_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
            arr_clr_n_q <= (state_d != StClear);
            arr_we_q    <= (state_d == StFeed);
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign arr_clr_n = arr_clr_n_q;
    assign arr_we    = arr_we_q;
    assign a_out0    = a_q[0];
    assign a_out1    = a_q[1];
    assign a_out2    = a_q[2];
    assign a_out3    = a_q[3];
    assign b_out0    = b_q[0];
    assign b_out1    = b_q[1];
    assign b_out2    = b_q[2];
    assign b_out3    = b_q[3];

`ifdef SEQ_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Perf counters.
    // job_cnt wraps; busy_cyc saturates, so a long run never reads as a short one.
    // ------------------------------------------------------------------
    logic [15:0] job_cnt_q, busy_cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_cnt_q  <= 16'd0;
            busy_cyc_q <= 16'd0;
        end else begin
            if (state_q == StDone) begin
                job_cnt_q <= job_cnt_q + 16'd1;
            end
            if (busy_q && (busy_cyc_q != 16'hFFFF)) begin
                busy_cyc_q <= busy_cyc_q + 16'd1;
            end
        end
    end

    assign job_cnt  = job_cnt_q;
    assign busy_cyc = busy_cyc_q;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Testbench for systolic_seq.
// The bench includes a behavioural 4x4 output-stationary MAC array that the
// sequencer drives. Each job pushes its hand-computed C matrix into a queue.
// A monitor pops one entry on every done pulse and compares it with the
// model's accumulators.

module tb_systolic_seq;

    localparam int DW = 8;

    typedef logic [16*32-1:0] mat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [3:0]    wr_addr = 4'd0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          busy, done, arr_clr_n, arr_we;
    logic [DW-1:0] a_out0, a_out1, a_out2, a_out3;
    logic [DW-1:0] b_out0, b_out1, b_out2, b_out3;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]   job_cnt, busy_cyc;
`endif

    always #5 clk = ~clk;

    systolic_seq #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .arr_clr_n (arr_clr_n),
        .arr_we    (arr_we),
        .a_out0    (a_out0),
        .a_out1    (a_out1),
        .a_out2    (a_out2),
        .a_out3    (a_out3),
        .b_out0    (b_out0),
        .b_out1    (b_out1),
        .b_out2    (b_out2),
        .b_out3    (b_out3)
`ifdef SEQ_PERF_CNT_EN
        ,
        .job_cnt   (job_cnt),
        .busy_cyc  (busy_cyc)
`endif
    );

    // ---------------- behavioural array ----------------
    logic [DW-1:0] a_in [4];
    logic [DW-1:0] b_in [4];
    assign a_in[0] = a_out0;
    assign a_in[1] = a_out1;
    assign a_in[2] = a_out2;
    assign a_in[3] = a_out3;
    assign b_in[0] = b_out0;
    assign b_in[1] = b_out1;
    assign b_in[2] = b_out2;
    assign b_in[3] = b_out3;

    logic        arr_rst_n;
    logic [DW-1:0] pa [4][4];
    logic [DW-1:0] pb [4][4];
    logic [31:0] acc [4][4];

    assign arr_rst_n = rst_n & arr_clr_n;

    function automatic logic [DW-1:0] pe_a(input int i, input int j);
        if (j == 0) return a_in[i];
        return pa[i][j-1];
    endfunction

    function automatic logic [DW-1:0] pe_b(input int i, input int j);
        if (i == 0) return b_in[j];
        return pb[i-1][j];
    endfunction

    always @(posedge clk or negedge arr_rst_n) begin
        if (!arr_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= 32'd0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    pa[i][j] <= pe_a(i, j);
                    pb[i][j] <= pe_b(i, j);
                    if (arr_we) acc[i][j] <= acc[i][j] + 32'(pe_a(i, j)) * 32'(pe_b(i, j));
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    mat_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   n_jobs = 0;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        mat_t e;
        if (rst_n && done) begin
            n_done++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at %0t, required no pending job", $time);
            end else begin
                e = exp_q.pop_front();
                for (int k = 0; k < 16; k++) begin
                    n_cmp++;
                    if (acc[k/4][k%4] != e[k*32 +: 32]) begin
                        n_bad++;
                        $display("FAIL c[%0d][%0d]: got %0d, required %0d",
                                 k/4, k%4, acc[k/4][k%4], e[k*32 +: 32]);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic mat_t const_mat(input int v);
        mat_t m;
        for (int k = 0; k < 16; k++) m[k*32 +: 32] = 32'(v);
        return m;
    endfunction

    task automatic wr(input logic sel, input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = DW'(data);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Optional write issued in the same cycle as start.
    logic    pend_wr = 1'b0;
    logic    pend_sel = 1'b0;
    int      pend_addr = 0;
    int      pend_data = 0;

    // mode 0: plain job; 1: check the edge outputs at FEED t=3;
    // 2: hold start for the whole job and try to write A[0][0]=99 during FEED.
    task automatic run_job(input mat_t e, input int mode);
        int n;
        int busy_n;
        int done0;
        exp_q.push_back(e);
        n_jobs++;
        done0 = n_done;
        @(negedge clk);
        start = 1'b1;
        if (pend_wr) begin
            wr_en   = 1'b1;
            wr_sel  = pend_sel;
            wr_addr = 4'(pend_addr);
            wr_data = DW'(pend_data);
        end
        @(posedge clk);  // start sampled here
        #1;
        if (mode != 2) start = 1'b0;
        wr_en   = 1'b0;
        pend_wr = 1'b0;
        n = -1;
        busy_n = 0;
        for (int c = 0; c <= 30; c++) begin
            if (busy) busy_n++;
            if (mode == 1 && c == 4) begin
                check("t3_a_out0", int'(a_out0), 4);
                check("t3_a_out1", int'(a_out1), 3);
                check("t3_a_out2", int'(a_out2), 2);
                check("t3_a_out3", int'(a_out3), 1);
                check("t3_b_out0", int'(b_out0), 1);
                check("t3_b_out3", int'(b_out3), 1);
                check("t3_arr_we", int'(arr_we), 1);
            end
            if (mode == 2 && c == 3) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 4'd0;
                wr_data = DW'(99);
            end
            if (mode == 2 && c == 5) wr_en = 1'b0;
            if (done) begin
                n = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (n < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done within 30 cycles, required done");
        end else begin
            // done follows the start-sampling edge by 11 edges: the 12th cycle of busy
            check("done_latency_edges", n, 11);
        end
        @(posedge clk);
        #1;
        check("busy_cycles", busy_n, 12);
        check("busy_after_done", int'(busy), 0);
        check("done_single_cycle", int'(done), 0);
        if (mode == 2) repeat (15) @(posedge clk);
        #1;
        check("one_done_per_job", n_done - done0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_arr_we", int'(arr_we), 0);
        check("rst_arr_clr_n", int'(arr_clr_n), 1);
        check("rst_a_out0", int'(a_out0), 0);
        check("rst_b_out3", int'(b_out3), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Freshly reset buffers are zero
        run_job(const_mat(0), 0);

        // Identity: A = I, B[r][c] = 4r+c+1; last B element is written with start
        for (int k = 0; k < 16; k++) wr(1'b0, k, (k / 4 == k % 4) ? 1 : 0);
        for (int k = 0; k < 15; k++) wr(1'b1, k, k + 1);
        wr(1'b1, 15, 0);
        pend_wr = 1'b1; pend_sel = 1'b1; pend_addr = 15; pend_data = 16;
        begin
            mat_t m;
            for (int k = 0; k < 16; k++) m[k*32 +: 32] = 32'(k + 1);
            run_job(m, 0);
        end

        // Uniform: 4 * 2 * 3 = 24, and a rerun with no writes gives 24 again
        for (int k = 0; k < 16; k++) wr(1'b0, k, 2);
        for (int k = 0; k < 16; k++) wr(1'b1, k, 3);
        run_job(const_mat(24), 0);
        run_job(const_mat(24), 0);

        // Skew: A[i][k] = k+1, B = 1 -> 1+2+3+4 = 10
        for (int k = 0; k < 16; k++) wr(1'b0, k, (k % 4) + 1);
        for (int k = 0; k < 16; k++) wr(1'b1, k, 1);
        run_job(const_mat(10), 1);

        // Protection: a write during FEED is dropped, and a held start gives a single done
        run_job(const_mat(10), 2);
        run_job(const_mat(10), 0);

        // Reset during FEED t=5
        d0 = n_done;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("feed_t5_we", int'(arr_we), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_arr_we", int'(arr_we), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_arr_clr_n", int'(arr_clr_n), 1);
        check("midrst_a_out1", int'(a_out1), 0);
        check("midrst_b_out2", int'(b_out2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_done", n_done - d0, 0);
        // Buffers were zeroed by the reset
        run_job(const_mat(0), 0);
        for (int k = 0; k < 16; k++) wr(1'b0, k, 2);
        for (int k = 0; k < 16; k++) wr(1'b1, k, (k / 4) + 1);
        run_job(const_mat(20), 0);  // 2*(1+2+3+4)

`ifdef SEQ_PERF_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("perf_rst_job_cnt", int'(job_cnt), 0);
        check("perf_rst_busy_cyc", int'(busy_cyc), 0);
        run_job(const_mat(0), 0);
        run_job(const_mat(0), 0);
        run_job(const_mat(0), 0);
        repeat (2) @(posedge clk);
        #1;
        check("perf_job_cnt", int'(job_cnt), 3);
        check("perf_busy_cyc", int'(busy_cyc), 36);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("total_dones", n_done, n_jobs);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_seq.md
# systolic_seq

Sequencer for the 4x4 systolic MAC array. Holds a 4x4 A (activation) tile and a 4x4 B (weight) tile in local registers, loaded by a host write port. On `start` it clears the array accumulators, then drives the array's row/column edge inputs with the diagonal skew the array requires, holding `we` for the whole compute window. When the window ends it pulses `done`; all 16 array outputs then hold C = A×B. It sits between the host/control logic and the `a_in*`/`b_in*`/`we` pins of the array.

## Interface
- DATA_WIDTH, 8, element width of A and B; matches the array.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe for the tile buffers.
- wr_sel  in  1  0 = A buffer, 1 = B buffer.
- wr_addr  in  4  element index, row*4+col.
- wr_data  in  DATA_WIDTH  element value.
- start  in  1  begin a job; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; results valid on array `c*` outputs.
- arr_clr_n  out  1  active-low accumulator clear; integrator ANDs it with rst_n at the array's rst_n.
- arr_we  out  1  array write enable.
- a_out0..a_out3  out  DATA_WIDTH each  to array a_in0..a_in3 (row edge).
- b_out0..b_out3  out  DATA_WIDTH each  to array b_in0..b_in3 (column edge).

## Operation
- States: IDLE → CLEAR → FEED → DONE → IDLE.
- IDLE: buffer writes accepted. start=1 → CLEAR. start is ignored in every other state.
- CLEAR (1 cycle): arr_clr_n=0, arr_we=0, edge outputs 0.
- FEED (10 cycles, step counter t=0..9): arr_we=1.
  - a_out_i = A[i][t-i] when 0≤t-i≤3, else 0.
  - b_out_j = B[t-j][j] when 0≤t-j≤3, else 0.
  - From t=7 to t=9 all edge outputs are 0 (drain); the zeros contribute nothing to the sums.
  - The counter wraps to 0 on leaving FEED.
- DONE (1 cycle): done=1, arr_we=0, edge outputs 0 → IDLE.
- Buffer writes are accepted only in IDLE. A write arriving in any other state is dropped, so the tile is stable for the whole job.
- Buffers persist across jobs. Rerunning without rewriting reproduces the same result.
- The block performs no arithmetic. Signedness and accumulator width are defined by the array.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, arr_we=0, arr_clr_n=1, all a_out/b_out=0, state=IDLE, t=0, all 32 buffer entries=0.
- A start sampled at edge E0 produces the following:
  - CLEAR in the cycle after E0.
  - FEED t=0 after E1.
  - FEED t=9 after E10.
  - DONE after E11.
  - IDLE after E12.
- Start-to-done latency is 12 cycles. busy is high for exactly 12 cycles.
- Back-to-back jobs: a start held high during DONE is ignored. The earliest next start is sampled in the first IDLE cycle, giving 13 cycles per job minimum.
- A write and a start in the same IDLE cycle: the write is committed and the job uses the new value.
- Reset asserted mid-job: immediate return to the reset values. arr_we drops asynchronously, no done is pulsed, and the buffers are zeroed.

## Configuration
- SEQ_PERF_CNT_EN defined: adds output `job_cnt` (16 bits, reset 0).
  - Increments by 1 in each DONE cycle and wraps 0xFFFF→0.
  - Adds output `busy_cyc` (16 bits, reset 0), incremented every cycle busy=1 and saturating at 0xFFFF.
- SEQ_PERF_CNT_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Identity: A=I, B[r][c]=4r+c+1, start → done 12 cycles after start; array C[r][c]=4r+c+1 for all 16 elements.
- Uniform: A all 2, B all 3 → every C=24. Immediate rerun with no writes → every C=24 again, not 48.
- Skew check: A[i][k]=k+1 and B[k][j]=1 → every C=10. In FEED t=3, expect a_out0..3 = 4,3,2,1 and b_out0..3 = 1,1,1,1.
- Protection: start held high during a job and wr_en writing A[0][0]=99 during FEED → only one done; result unchanged; A[0][0] keeps its old value on the next job.
- Reset at FEED t=5: arr_we=0 and all outputs at reset values immediately. No done. A new job after rewriting the tiles gives correct results.
- With SEQ_PERF_CNT_EN: three jobs → job_cnt=3, busy_cyc=36.
